// File: rtl/fpa_sched_pkg.sv
// Shared types for the FP-core round-robin scheduler:
// FSM states, word width and the in-flight tag record.
package fpa_sched_pkg;

   localparam int FP_W     = 32;
   localparam int MAX_ID_W = 3;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALT
   } state_e;

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: scans from ptr upward
// (mod NUM_REQ) and grants the first active request.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr < NUM_REQ, so one conditional subtract is a full modulo
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/fpa_sched.sv
// Shares one pipelined FP core among NUM_REQ requesters, tags each
// issue with its requester ID and steers the result back on retire.
module fpa_sched
   import fpa_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 1,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*FP_W-1:0] req_a,
   input  logic [NUM_REQ*FP_W-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [FP_W-1:0]         resp_data,
   output logic [FP_W-1:0]         fpu_a,
   output logic [FP_W-1:0]         fpu_b,
   output logic                    fpu_valid,
   input  logic [FP_W-1:0]         fpu_result,
   input  logic                    flush_req,
   output logic                    flush_done
);

   localparam int CNT_W = $clog2(LATENCY+1);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                flush_done_q, flush_done_d;
   tag_t                tag_q [LATENCY];
   tag_t                tag_d [LATENCY];

   logic                run_en;
   logic [NUM_REQ-1:0]  req_m;
   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gnt_id;
   logic                issue;
   logic                retire;
   logic [MAX_ID_W-1:0] ret_id;

   // flush_req gates grants in the very cycle it rises
   assign run_en = rst_n & (state_q == ST_RUN) & ~flush_req;
   assign req_m  = req_valid & {NUM_REQ{run_en}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req    (req_m),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign issue      = |gnt;
   assign req_ready  = gnt;
   assign fpu_valid  = issue;
   assign retire     = tag_q[LATENCY-1].valid;
   assign ret_id     = tag_q[LATENCY-1].id;
   assign flush_done = flush_done_q & rst_n;

   always_comb begin
      fpu_a = '0;
      fpu_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            fpu_a = req_a[i*FP_W +: FP_W];
            fpu_b = req_b[i*FP_W +: FP_W];
         end
      end
   end

   always_comb begin
      resp_valid = '0;
      resp_data  = '0;
      if (rst_n && retire) begin
         resp_data = fpu_result;
         for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = (ret_id == MAX_ID_W'(i));
         end
      end
   end

   always_comb begin
      tag_d[0].valid = issue;
      tag_d[0].id    = MAX_ID_W'(gnt_id);
      for (int s = 1; s < LATENCY; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(retire);
   end

   // DRAIN looks at the post-retire count so HALT follows the last retire
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (flush_req)     state_d = ST_DRAIN;
         ST_DRAIN: if (cnt_d == '0)   state_d = ST_HALT;
         ST_HALT:  if (!flush_req)    state_d = ST_RUN;
         default:                     state_d = ST_RUN;
      endcase
      flush_done_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         ptr_q        <= '0;
         cnt_q        <= '0;
         flush_done_q <= 1'b0;
         for (int s = 0; s < LATENCY; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         flush_done_q <= flush_done_d;
         for (int s = 0; s < LATENCY; s++) begin
            tag_q[s] <= tag_d[s];
         end
      end
   end

endmodule

// File: tb/tb_fpa_sched.sv
// Bench for fpa_sched: a LATENCY=1 and a LATENCY=3 instance driven from
// a vector table plus hand sequences, responses checked via scoreboard.
module tb_fpa_sched;

   typedef struct {
      int         sel;
      logic       rst;
      logic [3:0] rv;
      logic       fl;
      logic [3:0] gnt;
      logic       done;
   } vec_t;

   typedef struct {
      int          due;
      logic [3:0]  oh;
      logic [31:0] data;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_valid_v  [2];
   logic [127:0] req_a_v      [2];
   logic [127:0] req_b_v      [2];
   logic         flush_v      [2];
   logic [3:0]   req_ready_v  [2];
   logic [3:0]   resp_valid_v [2];
   logic [31:0]  resp_data_v  [2];
   logic [31:0]  fpu_a_v      [2];
   logic [31:0]  fpu_b_v      [2];
   logic         fpu_valid_v  [2];
   logic [31:0]  fpu_result_v [2];
   logic         flush_done_v [2];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   nstep = 0;
   sb_t  sb0 [$];
   sb_t  sb1 [$];
   vec_t tbl [$];

   logic [31:0] p1;
   logic [31:0] p3 [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpa_sched #(.NUM_REQ(4), .LATENCY(1)) u_dut_l1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_v[0]),
      .req_a      (req_a_v[0]),
      .req_b      (req_b_v[0]),
      .req_ready  (req_ready_v[0]),
      .resp_valid (resp_valid_v[0]),
      .resp_data  (resp_data_v[0]),
      .fpu_a      (fpu_a_v[0]),
      .fpu_b      (fpu_b_v[0]),
      .fpu_valid  (fpu_valid_v[0]),
      .fpu_result (fpu_result_v[0]),
      .flush_req  (flush_v[0]),
      .flush_done (flush_done_v[0])
   );

   fpa_sched #(.NUM_REQ(4), .LATENCY(3)) u_dut_l3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_v[1]),
      .req_a      (req_a_v[1]),
      .req_b      (req_b_v[1]),
      .req_ready  (req_ready_v[1]),
      .resp_valid (resp_valid_v[1]),
      .resp_data  (resp_data_v[1]),
      .fpu_a      (fpu_a_v[1]),
      .fpu_b      (fpu_b_v[1]),
      .fpu_valid  (fpu_valid_v[1]),
      .fpu_result (fpu_result_v[1]),
      .flush_req  (flush_v[1]),
      .flush_done (flush_done_v[1])
   );

   function automatic logic [63:0] s2d(input logic [31:0] s);
      logic [10:0] e;
      if (s[30:23] == 8'hFF)      e = 11'h7FF;
      else if (s[30:23] == 8'h00) e = 11'h000;
      else                        e = {3'b0, s[30:23]} + 11'd896;
      return {s[31], e, s[22:0], 29'b0};
   endfunction

   function automatic logic [31:0] d2s(input logic [63:0] d);
      logic [7:0] e;
      if (d[62:52] == 11'h7FF)      e = 8'hFF;
      else if (d[62:52] == 11'h000) e = 8'h00;
      else                          e = 8'(d[62:52] - 11'd896);
      return {d[63], e, d[51:29]};
   endfunction

   function automatic logic [31:0] core_fn(input logic [31:0] a,
                                           input logic [31:0] b);
      real r;
      r = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b));
      return d2s($realtobits(r));
   endfunction

   // adder core models with matching latencies
   always @(posedge clk) begin
      p1    <= core_fn(fpu_a_v[0], fpu_b_v[0]);
      p3[0] <= core_fn(fpu_a_v[1], fpu_b_v[1]);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign fpu_result_v[0] = p1;
   assign fpu_result_v[1] = p3[2];

   function automatic int lat(input int j);
      return (j == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input logic [69:0] act,
                      input logic [69:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(input int j, input logic rst, input logic [3:0] rv,
                       input logic fl, input logic [3:0] g, input logic d);
      logic [31:0] ea;
      logic [31:0] eb;
      sb_t         e;
      @(negedge clk);
      rst_n = rst;
      if (!rst) begin
         sb0.delete();
         sb1.delete();
      end
      req_valid_v[j]   = rv;
      flush_v[j]       = fl;
      req_valid_v[1-j] = 4'b0;
      flush_v[1-j]     = 1'b0;
      ea = '0;
      eb = '0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) begin
            ea = req_a_v[j][32*i +: 32];
            eb = req_b_v[j][32*i +: 32];
         end
      end
      #2;
      chk($sformatf("vec%0d_dut%0d", nstep, j),
          {req_ready_v[j], fpu_valid_v[j], fpu_a_v[j], fpu_b_v[j],
           flush_done_v[j]},
          {g, |g, ea, eb, d});
      nstep++;
      if (g != 4'b0) begin
         e.due  = cyc + lat(j);
         e.oh   = g;
         e.data = core_fn(ea, eb);
         if (j == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
   endtask

   task automatic mon(input int j);
      sb_t         e;
      logic [35:0] want;
      want = '0;
      if (j == 0) begin
         if (sb0.size() > 0 && sb0[0].due == cyc) begin
            e    = sb0.pop_front();
            want = {e.oh, e.data};
         end
      end else begin
         if (sb1.size() > 0 && sb1[0].due == cyc) begin
            e    = sb1.pop_front();
            want = {e.oh, e.data};
         end
      end
      chk($sformatf("resp_c%0d_dut%0d", cyc, j),
          {34'b0, resp_valid_v[j], resp_data_v[j]}, {34'b0, want});
   endtask

   always @(negedge clk) begin
      #3;
      mon(0);
      mon(1);
   end

   function automatic void add(input int s, input logic r,
                               input logic [3:0] rv, input logic fl,
                               input logic [3:0] g, input logic d);
      vec_t v;
      v.sel  = s;
      v.rst  = r;
      v.rv   = rv;
      v.fl   = fl;
      v.gnt  = g;
      v.done = d;
      tbl.push_back(v);
   endfunction

   initial begin
      for (int j = 0; j < 2; j++) begin
         req_valid_v[j] = 4'b0;
         flush_v[j]     = 1'b0;
         for (int i = 0; i < 4; i++) begin
            req_a_v[j][32*i +: 32] = 32'h3F80_0000 | (32'(i) << 20);
            req_b_v[j][32*i +: 32] = 32'h4000_0000 | (32'(i) << 19);
         end
      end

      // reset holds every output low
      add(0, 0, 4'hF, 0, 4'h0, 0);
      add(1, 0, 4'hF, 0, 4'h0, 0);
      // L1: all four valid, strict rotation from 0
      for (int k = 0; k < 8; k++) add(0, 1, 4'hF, 0, 4'(1 << (k % 4)), 0);
      // L3: move ptr to 2, then 1 and 3 alternate starting at 3
      add(1, 1, 4'b0010, 0, 4'b0010, 0);
      add(1, 1, 4'b1010, 0, 4'b1000, 0);
      add(1, 1, 4'b1010, 0, 4'b0010, 0);
      add(1, 1, 4'b1010, 0, 4'b1000, 0);
      add(1, 1, 4'b1010, 0, 4'b0010, 0);
      // flush with three in flight
      add(1, 1, 4'hF, 0, 4'b0100, 0);
      add(1, 1, 4'hF, 0, 4'b1000, 0);
      add(1, 1, 4'hF, 0, 4'b0001, 0);
      add(1, 1, 4'hF, 1, 4'b0000, 0);
      add(1, 1, 4'hF, 1, 4'b0000, 0);
      add(1, 1, 4'hF, 1, 4'b0000, 0);
      add(1, 1, 4'hF, 1, 4'b0000, 1);
      add(1, 1, 4'hF, 0, 4'b0000, 1);
      add(1, 1, 4'hF, 0, 4'b0010, 0);
      add(1, 1, 4'hF, 0, 4'b0100, 0);
      // flush dropped mid-drain still passes through HALT
      add(1, 1, 4'hF, 0, 4'b1000, 0);
      add(1, 1, 4'hF, 1, 4'b0000, 0);
      add(1, 1, 4'hF, 0, 4'b0000, 0);
      add(1, 1, 4'hF, 0, 4'b0000, 0);
      add(1, 1, 4'hF, 0, 4'b0000, 1);
      add(1, 1, 4'hF, 0, 4'b0001, 0);
      // flush with nothing in flight: done two cycles later
      add(1, 1, 4'h0, 0, 4'b0000, 0);
      add(1, 1, 4'h0, 0, 4'b0000, 0);
      add(1, 1, 4'h0, 0, 4'b0000, 0);
      add(1, 1, 4'h0, 1, 4'b0000, 0);
      add(1, 1, 4'h0, 1, 4'b0000, 0);
      add(1, 1, 4'h0, 1, 4'b0000, 1);
      add(1, 1, 4'hF, 0, 4'b0000, 1);
      add(1, 1, 4'hF, 0, 4'b0010, 0);
      add(1, 1, 4'h0, 0, 4'b0000, 0);
      // reset with two in flight: tags dropped, ptr back to 0
      add(1, 1, 4'hF,    0, 4'b0100, 0);
      add(1, 1, 4'b0010, 0, 4'b0010, 0);
      add(1, 0, 4'hF,    0, 4'b0000, 0);
      add(1, 1, 4'hF,    0, 4'b0001, 0);
      for (int k = 0; k < 4; k++) add(1, 1, 4'h0, 0, 4'b0000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].sel, tbl[i].rst, tbl[i].rv, tbl[i].fl,
              tbl[i].gnt, tbl[i].done);
      end

      // 1.0 + 2.0 through requester 0 on the single-cycle core
      step(0, 1, 4'b0001, 0, 4'b0001, 0);
      step(0, 1, 4'b0000, 0, 4'b0000, 0);
      chk("add_1p2_l1", {38'b0, resp_data_v[0]}, {38'b0, 32'h4040_0000});

      // +Inf + qNaN routed back to requester 2 untouched
      req_a_v[1][64 +: 32] = 32'h7F80_0000;
      req_b_v[1][64 +: 32] = 32'h7FC0_0000;
      step(1, 1, 4'b0100, 0, 4'b0100, 0);
      for (int k = 0; k < 5; k++) step(1, 1, 4'h0, 0, 4'h0, 0);

      chk("sb_empty", 70'(sb0.size() + sb1.size()), 70'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fpa_sched.md
# fpa_sched

Round-robin scheduler that shares one floating-point arithmetic core (`top`, adder or multiplier per build configuration) among `NUM_REQ` independent requesters. It selects one requester per cycle and drives that requester's operands into the core. It tracks each issued operation's requester ID through a tag pipeline matched to the core latency, then routes the result back to the originating requester. A flush handshake drains all in-flight operations so the core can be reconfigured or idled safely.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LATENCY`, 1: core cycles from operand issue to valid `fpu_result`, 1..8.
- `ID_W`, `$clog2(NUM_REQ)`: tag width (derived).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  requester i has operands pending.
- `req_a`  in  NUM_REQ*32  operand A per requester, IEEE-754 single; slice i = bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  operand B per requester, same layout.
- `req_ready`  out  NUM_REQ  one-hot grant; the issue handshake is `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  NUM_REQ  one-hot; result for requester i is on `resp_data`.
- `resp_data`  out  32  result word.
- `fpu_a`, `fpu_b`  out  32 each  operands to the core.
- `fpu_valid`  out  1  an operation is issued this cycle.
- `fpu_result`  in  32  core output.
- `flush_req`  in  1  level request to stop issuing and drain.
- `flush_done`  out  1  the pipeline is empty and the scheduler is halted.

## Operation
- State machine:
  - RUN: issuing enabled.
  - DRAIN: no issue; waits for the in-flight count to reach 0.
  - HALT: no issue; `flush_done`=1.
- Transitions:
  - RUN→DRAIN when `flush_req`=1.
  - DRAIN→HALT when the in-flight count is 0, evaluated after that cycle's retire.
  - HALT→RUN when `flush_req`=0.
  - If `flush_req` deasserts during DRAIN, DRAIN still completes to HALT, then goes to RUN the next cycle.
- Grant rule:
  - Grants happen only when state==RUN and `flush_req`=0.
  - Priority starts at pointer `ptr` and scans `ptr`, `ptr+1`, … mod `NUM_REQ`. The first requester with `req_valid` set gets `req_ready`.
  - The grant is combinational from `req_valid`, `ptr` and state. At most one bit is set.
- Issue:
  - `fpu_a`/`fpu_b` are a combinational mux of the granted requester's operands.
  - `fpu_valid` = any grant.
  - With no grant, `fpu_a`/`fpu_b` = 0.
- Pointer update: on a grant to i, `ptr` ← (i+1) mod `NUM_REQ`. With no grant, `ptr` is unchanged.
- Tag pipeline:
  - `LATENCY` stages of {valid, ID}. Stage 0 loads {`fpu_valid`, granted ID} each cycle; the other stages shift.
  - Last stage valid ⇒ `resp_valid[ID]`=1 and `resp_data`=`fpu_result`. Otherwise `resp_valid`=0 and `resp_data`=0.
- In-flight counter, width `$clog2(LATENCY+1)`:
  - Increments on issue and decrements on retire.
  - Issue and retire in the same cycle leave it unchanged. It never exceeds `LATENCY`.
- Responses have no backpressure; requesters must accept `resp_valid` in the cycle it is presented.
- The scheduler does not inspect operand values. Zero, infinity, NaN and subnormal operands pass through untouched.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=RUN, `ptr`=0, tag pipeline cleared, in-flight count=0.
  - While `rst_n`=0: `req_ready`=0, `fpu_valid`=0, `resp_valid`=0, `resp_data`=0, `flush_done`=0.
- Reset mid-operation drops all in-flight tags; results returning afterwards are ignored.
- Latency: a handshake in cycle t gives `resp_valid` in cycle t+`LATENCY`.
- Throughput: one issue per cycle, back-to-back, no bubbles.
- `flush_req` rising in cycle t blocks any grant in cycle t (combinational gating). State is DRAIN from cycle t+1.
- With k operations in flight at entry to DRAIN, `flush_done` rises at most k+1 cycles later. With none in flight, it rises in cycle t+2.

## Structure
- Package `fpa_sched_pkg`: the state enum (RUN, DRAIN, HALT), the `FP_W`=32 constant, and the tag struct {valid, id}.
- Sub-module `rr_arbiter`: parameterised `NUM_REQ`. Inputs: request vector and `ptr`. Outputs: one-hot grant and granted ID. Purely combinational.
- The top level holds the FSM, `ptr`, the tag shift register and the in-flight counter.

## Test plan
- Single requester, adder build, `LATENCY`=1: req 0 issues A=0x3F800000, B=0x40000000. Required: `fpu_valid`=1 in the same cycle, then `resp_valid`=4'b0001 with `resp_data`=0x40400000 one cycle later.
- All four requesters held valid for 8 cycles from reset: grant order 0,1,2,3,0,1,2,3 with `fpu_valid`=1 every cycle. Each `resp_valid` one-hot follows its grant by `LATENCY`.
- `LATENCY`=3, requesters 1 and 3 valid, `ptr`=2: grant order 3,1,3,1. Responses are tagged in the same order, 3 cycles later.
- Flush with 3 operations in flight (`LATENCY`=3):
  - `req_ready`=0 from the `flush_req` cycle onward.
  - All 3 responses are delivered.
  - `flush_done` rises, and RUN resumes one cycle after `flush_req`=0.
- Reset mid-stream: `rst_n`=0 for one edge with 2 operations in flight. Required: no `resp_valid` afterwards for those operations, `ptr`=0, and the first grant goes to requester 0.
- Special operands: +Inf + NaN(0x7FC00000) through requester 2. Required: `resp_data` equals the core result unchanged and routes to `resp_valid[2]`.
